// File: rtl/red_stats_accumulator.sv
// red_stats_accumulator
// Collects relative error distance (RED) samples from the divider error
// path over a window of 2^LOG2_N accepted samples. At the end of the window
// it reports the mean, rounded half-up, and the largest sample seen. It never
// back-pressures the upstream stage, and it takes samples only while a
// window is open.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset; clears all state
//   start      opens or restarts a window; sampled every cycle, ignored in CALC
//   red_valid  red_in carries a sample this cycle
//   red_in     unsigned RED sample
//   red_ready  high while a window is open (ACCUM); informational only
//   busy       high in ACCUM or CALC
//   done       one-cycle pulse when mred/max_red are written
//   mred       rounded mean of the last completed window
//   max_red    maximum sample of the last completed window
//   sample_cnt samples accepted in the current window
module red_stats_accumulator #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned LOG2_N = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              red_valid,
  input  logic [XLEN-1:0]   red_in,
  output logic              red_ready,
  output logic              busy,
  output logic              done,
  output logic [XLEN-1:0]   mred,
  output logic [XLEN-1:0]   max_red,
  output logic [LOG2_N:0]   sample_cnt
);

  localparam int unsigned SUMW = XLEN + LOG2_N;
  localparam int unsigned WIN  = 1 << LOG2_N;
  localparam logic [LOG2_N:0] LAST_CNT = (LOG2_N + 1)'(WIN - 1);
  localparam logic [SUMW-1:0] HALF     = SUMW'(WIN / 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_CALC,
    S_DONE
  } state_t;

  state_t          state;
  logic [SUMW-1:0] sum;
  logic [XLEN-1:0] max_w;
  logic [SUMW-1:0] sum_rnd;

  // The rounding add cannot carry out of SUMW. The largest possible sum is
  // N*(2^XLEN-1), and adding N/2 to it still leaves it below 2^SUMW.
  assign sum_rnd   = sum + HALF;
  assign red_ready = (state == S_ACCUM);
  assign busy      = (state == S_ACCUM) || (state == S_CALC);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      sum        <= '0;
      max_w      <= '0;
      sample_cnt <= '0;
      done       <= 1'b0;
      mred       <= '0;
      max_red    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            sum        <= '0;
            max_w      <= '0;
            sample_cnt <= '0;
            state      <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          // start wins over a coincident valid; that sample is dropped
          if (start) begin
            sum        <= '0;
            max_w      <= '0;
            sample_cnt <= '0;
          end else if (red_valid) begin
            sum        <= sum + {{LOG2_N{1'b0}}, red_in};
            if (red_in > max_w) max_w <= red_in;
            sample_cnt <= sample_cnt + 1'b1;
            if (sample_cnt == LAST_CNT) state <= S_CALC;
          end
        end
        S_CALC: begin
          mred    <= sum_rnd[SUMW-1:LOG2_N];
          max_red <= max_w;
          done    <= 1'b1;
          state   <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_red_stats_accumulator.sv
module tb_red_stats_accumulator;

  logic        clk;
  logic        reset;
  logic        start;
  logic        red_valid;
  logic [31:0] red_in;
  logic        red_ready;
  logic        busy;
  logic        done;
  logic [31:0] mred;
  logic [31:0] max_red;
  logic [2:0]  sample_cnt;

  int checks = 0;
  int errors = 0;

  red_stats_accumulator #(.XLEN(32), .LOG2_N(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .red_valid  (red_valid),
    .red_in     (red_in),
    .red_ready  (red_ready),
    .busy       (busy),
    .done       (done),
    .mred       (mred),
    .max_red    (max_red),
    .sample_cnt (sample_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][31:0] s;
    logic [31:0]      m;
    logic [31:0]      x;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of stimulus. Every step taken inside a window must show done low.
  task automatic feed(input logic v, input logic [31:0] d);
    red_valid = v;
    red_in    = d;
    tick();
    red_valid = 1'b0;
    chk("done_low_accum", 64'(done), 64'd0);
  endtask

  task automatic open_window();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ready_after_start", 64'(red_ready), 64'd1);
    chk("cnt_after_start", 64'(sample_cnt), 64'd0);
  endtask

  // Called in the CALC cycle, which directly follows the 4th accepted sample.
  task automatic expect_done(input logic [31:0] em, input logic [31:0] ex, input logic start_in_calc);
    chk("calc_busy", 64'(busy), 64'd1);
    chk("calc_not_ready", 64'(red_ready), 64'd0);
    chk("calc_cnt", 64'(sample_cnt), 64'd4);
    start = start_in_calc;
    tick();
    start = 1'b0;
    chk("done_pulse", 64'(done), 64'd1);
    chk("mred", 64'(mred), 64'(em));
    chk("max_red", 64'(max_red), 64'(ex));
    chk("cnt_done", 64'(sample_cnt), 64'd4);
    tick();
    chk("done_drop", 64'(done), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("mred_hold", 64'(mred), 64'(em));
  endtask

  initial begin
    logic [31:0] prev_m;

    vecs[0].s = {32'd4, 32'd3, 32'd2, 32'd1};                 vecs[0].m = 32'd3;          vecs[0].x = 32'd4;
    vecs[1].s = {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
                                                              vecs[1].m = 32'hFFFFFFFF;   vecs[1].x = 32'hFFFFFFFF;
    vecs[2].s = {32'd1, 32'd0, 32'd0, 32'd0};                 vecs[2].m = 32'd0;          vecs[2].x = 32'd1;
    vecs[3].s = {32'd1, 32'd1, 32'd0, 32'd0};                 vecs[3].m = 32'd1;          vecs[3].x = 32'd1;
    vecs[4].s = {32'd0, 32'd0, 32'd0, 32'd7};                 vecs[4].m = 32'd2;          vecs[4].x = 32'd7;
    vecs[5].s = {32'h7FFFFFFF, 32'd0, 32'd0, 32'h80000000};   vecs[5].m = 32'h40000000;   vecs[5].x = 32'h80000000;

    start = 1'b0; red_valid = 1'b0; red_in = '0;
    reset = 1'b0;
    #12;
    chk("rst_ready", 64'(red_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_mred", 64'(mred), 64'd0);
    chk("rst_max", 64'(max_red), 64'd0);
    chk("rst_cnt", 64'(sample_cnt), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Valids in IDLE are ignored, and so is a valid that arrives with start.
    red_valid = 1'b1; red_in = 32'd8;
    tick();
    tick();
    chk("idle_cnt", 64'(sample_cnt), 64'd0);
    chk("idle_busy0", 64'(busy), 64'd0);
    start = 1'b1;
    tick();
    start = 1'b0; red_valid = 1'b0;
    chk("start_valid_cnt", 64'(sample_cnt), 64'd0);
    for (int i = 0; i < 4; i++) feed(1'b1, 32'd1);
    expect_done(32'd1, 32'd1, 1'b0);
    prev_m = 32'd1;

    // Table of back-to-back windows. start in CALC must be ignored.
    foreach (vecs[k]) begin
      open_window();
      chk("mred_kept_on_start", 64'(mred), 64'(prev_m));
      for (int i = 0; i < 4; i++) feed(1'b1, vecs[k].s[i]);
      expect_done(vecs[k].m, vecs[k].x, (k % 2) == 1);
      prev_m = vecs[k].m;
    end

    // valid gaps: 5,_,_,7,_,9,2 gives a sum of 23
    open_window();
    feed(1'b1, 32'd5);
    feed(1'b0, 32'd99);
    feed(1'b0, 32'd99);
    feed(1'b1, 32'd7);
    feed(1'b0, 32'd99);
    feed(1'b1, 32'd9);
    chk("gap_cnt3", 64'(sample_cnt), 64'd3);
    chk("gap_ready", 64'(red_ready), 64'd1);
    feed(1'b1, 32'd2);
    expect_done(32'd6, 32'd9, 1'b0);

    // A restart in mid-window discards the earlier 100s.
    open_window();
    feed(1'b1, 32'd100);
    feed(1'b1, 32'd100);
    chk("pre_restart_cnt", 64'(sample_cnt), 64'd2);
    start = 1'b1; red_valid = 1'b1; red_in = 32'd100;
    tick();
    start = 1'b0; red_valid = 1'b0;
    chk("restart_cnt", 64'(sample_cnt), 64'd0);
    chk("restart_no_done", 64'(done), 64'd0);
    for (int i = 0; i < 4; i++) feed(1'b1, 32'd4);
    expect_done(32'd4, 32'd4, 1'b0);

    // An asynchronous reset after 3 samples aborts the window.
    open_window();
    for (int i = 0; i < 3; i++) feed(1'b1, 32'd50);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_mred", 64'(mred), 64'd0);
    chk("arst_max", 64'(max_red), 64'd0);
    chk("arst_cnt", 64'(sample_cnt), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_ready", 64'(red_ready), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    red_valid = 1'b1; red_in = 32'd50;
    tick();
    tick();
    red_valid = 1'b0;
    chk("post_rst_done", 64'(done), 64'd0);
    chk("post_rst_cnt", 64'(sample_cnt), 64'd0);
    open_window();
    for (int i = 0; i < 4; i++) feed(1'b1, 32'd2);
    expect_done(32'd2, 32'd2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
